// File: rtl/commit_monitor_pkg.sv
// ============================================================================
// Module   : commit_monitor_pkg
// Purpose  : Shared types and constants for the commit monitor: monitor state
//            encoding, errcode bit positions and default parameter values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package commit_monitor_pkg;

  // Monitor life cycle: commits are only observed while in ST_RUN.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit positions inside errcode.
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_RW      = 1;
  localparam int ERR_MEM     = 2;
  localparam int ERR_W       = 3;

  // Default configuration.
  localparam int NUM_CH_DEF         = 2;
  localparam int TIMEOUT_CYCLES_DEF = 100000;
  localparam int DRAIN_CYCLES_DEF   = 30;

  // Per-lane counts never exceed 4 lanes, so 3 bits cover 0..4.
  localparam int LANE_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/commit_lane_prefix.sv
// ============================================================================
// Module   : commit_lane_prefix
// Purpose  : Per-lane prefix count of valid lanes, halt-lane detection
//            (lowest valid lane whose PC does not move) and the number of
//            lanes retired this cycle (valid lanes up to and including the
//            halt lane).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_lane_prefix
  import commit_monitor_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic [NUM_CH-1:0]                 valid_i,
  input  logic [NUM_CH-1:0][31:0]           pc_rdata_i,
  input  logic [NUM_CH-1:0][31:0]           pc_wdata_i,
  output logic [NUM_CH-1:0][LANE_CNT_W-1:0] prefix_o,
  output logic [LANE_CNT_W-1:0]             retire_cnt_o,
  output logic                              halt_o
);

  localparam logic [LANE_CNT_W-1:0] CNT_ONE = 1;

  logic [LANE_CNT_W-1:0] run_cnt;
  logic [LANE_CNT_W-1:0] ret_cnt;
  logic                  halt_seen;

  // Walk lanes low to high; prefix ignores halts, retire count stops after the halt lane.
  always_comb begin
    run_cnt   = '0;
    ret_cnt   = '0;
    halt_seen = 1'b0;
    prefix_o  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      prefix_o[i] = run_cnt;
      if (valid_i[i]) begin
        run_cnt = run_cnt + CNT_ONE;
        if (!halt_seen) begin
          ret_cnt = ret_cnt + CNT_ONE;
          if (pc_rdata_i[i] == pc_wdata_i[i]) begin
            halt_seen = 1'b1;
          end
        end
      end
    end
    retire_cnt_o = ret_cnt;
    halt_o       = halt_seen;
  end

endmodule

`default_nettype wire

// File: rtl/commit_monitor.sv
// ============================================================================
// Module   : commit_monitor
// Purpose  : Retirement monitor. Counts retired instructions, assigns per-lane
//            order numbers, detects halt (PC self-loop), commit timeout and
//            memory errors, then drains for a fixed time before reporting done.
// Config   : COMMIT_MONITOR_RWCHK_EN - when defined, a simultaneous mem_read and
//            mem_write raises errcode[1]; otherwise errcode[1] stays 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_monitor
  import commit_monitor_pkg::*;
#(
  parameter int NUM_CH         = NUM_CH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       commit_valid,
  input  logic [NUM_CH-1:0][31:0] commit_pc_rdata,
  input  logic [NUM_CH-1:0][31:0] commit_pc_wdata,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic                    mem_error,
  output logic [63:0]             order,
  output logic [NUM_CH-1:0][63:0] lane_order,
  output logic [ERR_W-1:0]        errcode,
  output logic                    halted,
  output logic                    done
);

  state_e            state_q,   state_d;
  logic [63:0]       order_q,   order_d;
  logic [ERR_W-1:0]  errcode_q, errcode_d;
  logic              halted_q,  halted_d;
  logic [31:0]       tmo_q,     tmo_d;
  logic [31:0]       drain_q,   drain_d;

  logic [NUM_CH-1:0][LANE_CNT_W-1:0] w_prefix;
  logic [LANE_CNT_W-1:0]             w_retire_cnt;
  logic                              w_halt;
  logic [ERR_W-1:0]                  w_err_set;
  logic [ERR_W-1:0]                  w_err_new;

  commit_lane_prefix #(
    .NUM_CH (NUM_CH)
  ) u_prefix (
    .valid_i      (commit_valid),
    .pc_rdata_i   (commit_pc_rdata),
    .pc_wdata_i   (commit_pc_wdata),
    .prefix_o     (w_prefix),
    .retire_cnt_o (w_retire_cnt),
    .halt_o       (w_halt)
  );

  // Each lane's order number is the running order plus valid lanes below it.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane_order
    assign lane_order[i] = order_q + 64'(w_prefix[i]);
  end

`ifndef COMMIT_MONITOR_RWCHK_EN
  logic w_unused_rw;
  assign w_unused_rw = mem_read ^ mem_write;
`endif

  // Error events raised this cycle; the timeout can only fire while running.
  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_TIMEOUT] = (state_q == ST_RUN) && (w_retire_cnt == '0) && (tmo_q == 32'd1);
`ifdef COMMIT_MONITOR_RWCHK_EN
    w_err_set[ERR_RW]      = mem_read & mem_write;
`endif
    w_err_set[ERR_MEM]     = mem_error;
    w_err_new              = w_err_set & ~errcode_q;
  end

  // Next-state logic: RUN counts commits, DRAIN waits out the drain time, DONE holds.
  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    errcode_d = errcode_q;
    halted_d  = halted_q;
    tmo_d     = tmo_q;
    drain_d   = drain_q;
    case (state_q)
      ST_RUN: begin
        order_d   = order_q + 64'(w_retire_cnt);
        errcode_d = errcode_q | w_err_set;
        if (w_retire_cnt != '0) begin
          tmo_d = 32'(TIMEOUT_CYCLES);
        end else if (tmo_q != 32'd0) begin
          tmo_d = tmo_q - 32'd1;
        end
        if (w_halt) begin
          halted_d = 1'b1;
        end
        // A new error outranks the halt for the state choice.
        if (w_err_new != '0) begin
          state_d = ST_DRAIN;
          drain_d = 32'(DRAIN_CYCLES);
        end else if (w_halt) begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: begin
        errcode_d = errcode_q | w_err_set;
        if (drain_q <= 32'd1) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 32'd1;
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      order_q   <= '0;
      errcode_q <= '0;
      halted_q  <= 1'b0;
      tmo_q     <= 32'(TIMEOUT_CYCLES);
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      errcode_q <= errcode_d;
      halted_q  <= halted_d;
      tmo_q     <= tmo_d;
      drain_q   <= drain_d;
    end
  end

  assign order   = order_q;
  assign errcode = errcode_q;
  assign halted  = halted_q;
  assign done    = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_commit_monitor.sv
// ============================================================================
// Module   : tb_commit_monitor
// Purpose  : Self-checking bench for commit_monitor: directed scenarios with
//            literal expectations plus randomized episodes compared every
//            cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_monitor;

  localparam int NCH = 2;
  localparam int TMO = 5;
  localparam int DRN = 6;
`ifdef COMMIT_MONITOR_RWCHK_EN
  localparam bit RWCHK = 1'b1;
`else
  localparam bit RWCHK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NCH-1:0]        commit_valid;
  logic [NCH-1:0][31:0]  commit_pc_rdata;
  logic [NCH-1:0][31:0]  commit_pc_wdata;
  logic                  mem_read, mem_write, mem_error;
  logic [63:0]           order;
  logic [NCH-1:0][63:0]  lane_order;
  logic [2:0]            errcode;
  logic                  halted, done;

  commit_monitor #(
    .NUM_CH         (NCH),
    .TIMEOUT_CYCLES (TMO),
    .DRAIN_CYCLES   (DRN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .commit_valid    (commit_valid),
    .commit_pc_rdata (commit_pc_rdata),
    .commit_pc_wdata (commit_pc_wdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_error       (mem_error),
    .order           (order),
    .lane_order      (lane_order),
    .errcode         (errcode),
    .halted          (halted),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model: phase 0 running, 1 draining, 2 finished.
  longint unsigned m_order;
  logic [2:0]      m_err;
  bit              m_halted;
  int              m_phase;
  int              m_idle;        // consecutive commit-free running cycles
  int              m_drain_left;  // edges remaining until finished

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_order = 0; m_err = 3'b000; m_halted = 0; m_phase = 0; m_idle = 0; m_drain_left = 0;
  endtask

  // Compare every output against the model for the inputs currently applied.
  task automatic compare_all();
    longint unsigned exp_lane;
    chk("order", order, m_order);
    chk("errcode", {61'd0, errcode}, {61'd0, m_err});
    chk("halted", {63'd0, halted}, {63'd0, m_halted});
    chk("done", {63'd0, done}, {63'd0, (m_phase == 2)});
    for (int i = 0; i < NCH; i++) begin
      exp_lane = m_order;
      for (int j = 0; j < i; j++) if (commit_valid[j]) exp_lane++;
      chk("lane_order", lane_order[i], exp_lane);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare.
  task automatic set_inputs(input logic [NCH-1:0] v, input logic [NCH-1:0] h,
                            input logic mr, input logic mw, input logic me);
    for (int i = 0; i < NCH; i++) begin
      commit_pc_rdata[i] = $urandom;
      commit_pc_wdata[i] = h[i] ? commit_pc_rdata[i] : commit_pc_rdata[i] + 32'd4;
    end
    commit_valid = v;
    mem_read = mr; mem_write = mw; mem_error = me;
    #1;
    compare_all();
  endtask

  // Advance the model by the rules for the applied inputs, then clock the DUT.
  task automatic step();
    int         ret;
    bit         hl;
    logic [2:0] newe;
    ret = 0; hl = 0; newe = 3'b000;
    if (m_phase == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_valid[i] && !hl) begin
          ret++;
          if (commit_pc_rdata[i] == commit_pc_wdata[i]) hl = 1;
        end
      end
      m_order += longint'(ret);
      m_idle = (ret > 0) ? 0 : m_idle + 1;
      if (m_idle == TMO) newe[0] = 1'b1;
      if (RWCHK && mem_read && mem_write) newe[1] = 1'b1;
      if (mem_error) newe[2] = 1'b1;
      newe = newe & ~m_err;
      m_err = m_err | newe;
      if (hl) m_halted = 1;
      if (newe != 3'b000) begin
        m_phase = 1; m_drain_left = DRN;
      end else if (hl) begin
        m_phase = 2;
      end
    end else if (m_phase == 1) begin
      if (RWCHK && mem_read && mem_write) m_err[1] = 1'b1;
      if (mem_error) m_err[2] = 1'b1;
      m_drain_left--;
      if (m_drain_left == 0) m_phase = 2;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset mid-cycle (no clock edge) and check immediately; commits offered
  // during the reset cycle must not be counted.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_inputs(NCH'($urandom), '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] v, h;
    int mode;
    rst_n = 1'b0;
    commit_valid = '0; commit_pc_rdata = '0; commit_pc_wdata = '0;
    mem_read = 0; mem_write = 0; mem_error = 0;
    model_reset();
    @(negedge clk);

    // Reset values.
    do_reset();
    chk("rst_order", order, 64'd0);
    chk("rst_errcode", {61'd0, errcode}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);

    // Lanes 11, 01, 10 -> order 0, 2, 3, 4.
    set_inputs(2'b11, 2'b00, 0, 0, 0);
    chk("seq_lane0", lane_order[0], 64'd0);
    chk("seq_lane1", lane_order[1], 64'd1);
    step();
    chk("seq_order2", order, 64'd2);
    set_inputs(2'b01, 2'b00, 0, 0, 0); step();
    chk("seq_order3", order, 64'd3);
    set_inputs(2'b10, 2'b00, 0, 0, 0);
    chk("seq_lane1_b", lane_order[1], 64'd3);
    step();
    chk("seq_order4", order, 64'd4);

    // Halt on lane 0: lane 1 ignored, done the next cycle.
    do_reset();
    set_inputs(2'b11, 2'b00, 0, 0, 0);
    commit_pc_rdata[0] = 32'h60; commit_pc_wdata[0] = 32'h60;
    step();
    chk("halt_order", order, 64'd1);
    chk("halt_halted", {63'd0, halted}, 64'd1);
    chk("halt_done", {63'd0, done}, 64'd1);
    chk("halt_err", {61'd0, errcode}, 64'd0);

    // Timeout after TMO commit-free cycles, done DRN edges later.
    do_reset();
    for (int c = 0; c < TMO - 1; c++) begin set_inputs('0, '0, 0, 0, 0); step(); end
    chk("tmo_early", {61'd0, errcode}, 64'd0);
    set_inputs('0, '0, 0, 0, 0); step();
    chk("tmo_err", {61'd0, errcode}, 64'd1);
    for (int c = 0; c < DRN - 1; c++) begin set_inputs('0, '0, 0, 0, 0); step(); end
    chk("tmo_not_done", {63'd0, done}, 64'd0);
    set_inputs('0, '0, 0, 0, 0); step();
    chk("tmo_done", {63'd0, done}, 64'd1);

    // Simultaneous read/write.
    do_reset();
    set_inputs(2'b11, 2'b00, 1, 1, 0); step();
    chk("rw_err", {61'd0, errcode}, RWCHK ? 64'd2 : 64'd0);

    // Memory error with halt in the same cycle: drain, not done.
    do_reset();
    set_inputs(2'b01, 2'b01, 0, 0, 1); step();
    chk("memhalt_err", {61'd0, errcode}, 64'd4);
    chk("memhalt_halted", {63'd0, halted}, 64'd1);
    chk("memhalt_done", {63'd0, done}, 64'd0);

    // Reset mid-drain with order 7.
    do_reset();
    for (int c = 0; c < 3; c++) begin set_inputs(2'b11, 2'b00, 0, 0, 0); step(); end
    set_inputs(2'b01, 2'b00, 0, 0, 1); step();
    set_inputs('0, '0, 0, 0, 0); step();
    chk("drain_order", order, 64'd7);
    chk("drain_err", {61'd0, errcode}, 64'd4);
    rst_n = 1'b0;
    #1;
    chk("async_order", order, 64'd0);
    chk("async_err", {61'd0, errcode}, 64'd0);
    chk("async_done", {63'd0, done}, 64'd0);
    @(negedge clk);

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 60; c++) begin
        case (mode)
          0:       v = NCH'($urandom);
          1:       v = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
          default: v = '1;
        endcase
        h = ($urandom_range(0, 11) == 0) ? NCH'($urandom) : '0;
        set_inputs(v, h, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 49) == 0));
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_monitor.md
COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 Parameter NUM_CH, 2, number of commit lanes per cycle (1..4).
REQ-002 Parameter TIMEOUT_CYCLES, 100000, commit-free cycles before timeout (>=1).
REQ-003 Parameter DRAIN_CYCLES, 30, cycles between first error and done (>=1).
REQ-004 Port clk  in  1  single clock, all state on rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Port commit_valid  in  NUM_CH  per-lane instruction retire strobe.
REQ-007 Port commit_pc_rdata  in  NUM_CH x 32  per-lane PC of retiring instruction.
REQ-008 Port commit_pc_wdata  in  NUM_CH x 32  per-lane next PC.
REQ-009 Port mem_read, mem_write  in  1 each  physical memory request strobes.
REQ-010 Port mem_error  in  1  external memory/shadow error strobe.
REQ-011 Port order  out  64  count of retired instructions.
REQ-012 Port lane_order  out  NUM_CH x 64  order number assigned to each lane this cycle.
REQ-013 Port errcode  out  3  sticky error flags: [0] timeout, [1] simultaneous read/write, [2] memory error.
REQ-014 Port halted, done  out  1 each  halt seen; monitor finished.

Function
REQ-015 Monitor SHALL have states RUN, DRAIN, DONE; only RUN observes commits.
REQ-016 lane_order[i] SHALL equal order plus count of valid lanes with index < i, combinationally.
REQ-017 A halt lane SHALL be a valid lane with commit_pc_rdata == commit_pc_wdata; lowest-indexed such lane wins.
REQ-018 In RUN, order SHALL advance by number of valid lanes up to and including the halt lane (all valid lanes if none); lanes above the halt lane are ignored.
REQ-019 order SHALL wrap modulo 2^64 without flagging.
REQ-020 Timeout counter SHALL reload to TIMEOUT_CYCLES on any counted commit, else decrement in RUN; transition 1->0 SHALL set errcode[0].
REQ-021 mem_read && mem_write in the same cycle in RUN SHALL set errcode[1].
REQ-022 mem_error in RUN SHALL set errcode[2].
REQ-023 Halt lane in RUN with no new error SHALL set halted and move to DONE next cycle.
REQ-024 Any errcode bit newly set in RUN SHALL move to DRAIN, loading drain counter with DRAIN_CYCLES; halt in the same cycle still sets halted, error takes precedence for state.
REQ-025 DRAIN SHALL decrement drain counter each cycle; at 1 move to DONE; further errors in DRAIN are still recorded in errcode.
REQ-026 DONE SHALL be absorbing until reset; done = (state == DONE); errcode, order, halted frozen.

Reset
REQ-027 rst_n low SHALL immediately force state RUN, order 0, errcode 0, halted 0, done 0, timeout counter TIMEOUT_CYCLES, drain counter 0.
REQ-028 Reset assertion mid-DRAIN or mid-commit SHALL discard all in-progress counts; no commit is counted in a reset cycle.

Configuration
REQ-029 Macro COMMIT_MONITOR_RWCHK_EN: defined -> REQ-021 active; undefined -> errcode[1] tied 0 and mem_read/mem_write unused.

Structure
REQ-030 Package commit_monitor_pkg SHALL hold the state enum, errcode bit-index constants and default parameter values.
REQ-031 Sub-module commit_lane_prefix SHALL compute per-lane prefix counts, halt-lane masking and total retire count.

Verification
REQ-032 NUM_CH=2, lanes 11 then 01 then 10 for three cycles -> order 0->2->3->4; lane_order in cycle 1 = {0,1}.
REQ-033 Lane0 valid pc 0x60 -> 0x60, lane1 valid -> order +1, halted=1, done=1 next cycle, errcode=0.
REQ-034 TIMEOUT_CYCLES=5, no commits -> errcode=3'b001 after 5 cycles, done exactly DRAIN_CYCLES later.
REQ-035 mem_read=mem_write=1 one cycle with macro defined -> errcode=3'b010 and DRAIN; undefined -> errcode stays 0.
REQ-036 mem_error plus halt lane same cycle -> errcode=3'b100, halted=1, state DRAIN not DONE.
REQ-037 rst_n pulsed low mid-DRAIN (order=7) -> order 0, errcode 0, state RUN without waiting for clk.
